// File: rtl/video_pattern_pkg.sv
// video_pattern_pkg
//   Shared types and helpers for the video pattern source and any future
//   generator that reuses the pixel function.
//   - patternMode_t : SOLID / BARS / CHECKER / XOR selector values
//   - sourceState_t : request-handling state encodings
//   - requestBits() : width of a {row, chunk} request word
package video_pattern_pkg;

  typedef enum logic [1:0] {
    PATTERN_SOLID   = 2'd0,
    PATTERN_BARS    = 2'd1,
    PATTERN_CHECKER = 2'd2,
    PATTERN_XOR     = 2'd3
  } patternMode_t;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    READ    = 2'd1,
    CAPTURE = 2'd2,
    EMIT    = 2'd3
  } sourceState_t;

  // A request carries the full row plus the chunk column; the low CHUNK_BITS
  // of x come from the pixel counter, so they are not part of the word.
  function automatic int requestBits(input int yBits, input int xBits, input int chunkBits);
    return yBits + xBits - chunkBits;
  endfunction

endpackage

// File: rtl/video_pattern_pixel.sv
// video_pattern_pixel
//   Purely combinational test-pattern pixel function.
//   Ports:
//     x, y             : pixel coordinates
//     mode             : pattern selector (patternMode_t encoding)
//     foregroundColor  : primary color
//     backgroundColor  : secondary color
//     pixel            : generated pixel word
module video_pattern_pixel
  import video_pattern_pkg::*;
#(
  parameter int X_BITS         = 11,
  parameter int Y_BITS         = 11,
  parameter int BITS_PER_PIXEL = 16,
  parameter int CHECK_BITS     = 4
) (
  input  logic [X_BITS-1:0]         x,
  input  logic [Y_BITS-1:0]         y,
  input  logic [1:0]                mode,
  input  logic [BITS_PER_PIXEL-1:0] foregroundColor,
  input  logic [BITS_PER_PIXEL-1:0] backgroundColor,
  output logic [BITS_PER_PIXEL-1:0] pixel
);

  localparam int XY_BITS = (X_BITS > Y_BITS) ? X_BITS : Y_BITS;

  logic [XY_BITS-1:0] xorValue;

  always_comb begin
    xorValue = XY_BITS'(x) ^ XY_BITS'(y);
    pixel    = foregroundColor;
    case (patternMode_t'(mode))
      PATTERN_SOLID:   pixel = foregroundColor;
      // Top three x bits pick one of 8 bars; odd bars are foreground, and
      // oddness is just the lowest of those three bits.
      PATTERN_BARS:    pixel = x[X_BITS-3] ? foregroundColor : backgroundColor;
      PATTERN_CHECKER: pixel = (x[CHECK_BITS] ^ y[CHECK_BITS]) ? foregroundColor : backgroundColor;
      PATTERN_XOR:     pixel = BITS_PER_PIXEL'(xorValue);
      default:         pixel = foregroundColor;
    endcase
  end

endmodule

// File: rtl/video_pattern_source.sv
// video_pattern_source
//   Terminal pixel source: pops chunk requests from the upstream request
//   FIFO (non-FWFT) and pushes 2^CHUNK_BITS generated pixels per request
//   into the response FIFO.
//   Ports:
//     sourceClock, reset        : clock, synchronous active-high reset
//     patternMode               : 0=SOLID 1=BARS 2=CHECKER 3=XOR
//     foregroundColor           : primary color
//     backgroundColor           : secondary color
//     requestFifoReadEnable     : registered pop strobe
//     requestFifoEmpty          : request FIFO empty
//     requestFifoReadData       : {row, chunk} request word
//     responseFifoWriteEnable   : pixel push strobe (combinational)
//     responseFifoFull          : response FIFO full
//     responseFifoWriteData     : pixel word
//
//   state   | meaning
//   --------+-----------------------------------------------------------
//   IDLE    | waiting for a request; pops when the FIFO is non-empty
//   READ    | pop strobe high for this single cycle
//   CAPTURE | read data valid; latch request and pattern configuration
//   EMIT    | one pixel per non-full cycle until the chunk is complete
module video_pattern_source
  import video_pattern_pkg::*;
#(
  parameter  int CHUNK_BITS     = 5,
  parameter  int X_BITS         = 11,
  parameter  int Y_BITS         = 11,
  parameter  int BITS_PER_PIXEL = 16,
  parameter  int CHECK_BITS     = 4,
  localparam int REQUEST_BITS   = requestBits(Y_BITS, X_BITS, CHUNK_BITS)
) (
  input  logic                      sourceClock,
  input  logic                      reset,
  input  logic [1:0]                patternMode,
  input  logic [BITS_PER_PIXEL-1:0] foregroundColor,
  input  logic [BITS_PER_PIXEL-1:0] backgroundColor,
  output logic                      requestFifoReadEnable,
  input  logic                      requestFifoEmpty,
  input  logic [REQUEST_BITS-1:0]   requestFifoReadData,
  output logic                      responseFifoWriteEnable,
  input  logic                      responseFifoFull,
  output logic [BITS_PER_PIXEL-1:0] responseFifoWriteData
);

  localparam int CHUNK_COL_BITS = X_BITS - CHUNK_BITS;

  sourceState_t              state;
  sourceState_t              stateNext;
  logic                      readEnableNext;
  logic                      captureRequest;
  logic [CHUNK_BITS-1:0]     pixelCount;
  logic [CHUNK_BITS-1:0]     pixelCountNext;

  logic [Y_BITS-1:0]         rowLatched;
  logic [CHUNK_COL_BITS-1:0] chunkLatched;
  logic [1:0]                modeLatched;
  logic [BITS_PER_PIXEL-1:0] foregroundLatched;
  logic [BITS_PER_PIXEL-1:0] backgroundLatched;

  always_ff @(posedge sourceClock) begin
    if (reset) begin
      state                 <= IDLE;
      requestFifoReadEnable <= 1'b0;
      pixelCount            <= '0;
      rowLatched            <= '0;
      chunkLatched          <= '0;
      modeLatched           <= '0;
      foregroundLatched     <= '0;
      backgroundLatched     <= '0;
    end else begin
      state                 <= stateNext;
      requestFifoReadEnable <= readEnableNext;
      pixelCount            <= pixelCountNext;
      // Configuration is frozen here so mid-chunk input changes only
      // affect the next chunk.
      if (captureRequest) begin
        rowLatched        <= requestFifoReadData[REQUEST_BITS-1 -: Y_BITS];
        chunkLatched      <= requestFifoReadData[CHUNK_COL_BITS-1:0];
        modeLatched       <= patternMode;
        foregroundLatched <= foregroundColor;
        backgroundLatched <= backgroundColor;
      end
    end
  end

  always_comb begin
    stateNext               = state;
    readEnableNext          = 1'b0;
    captureRequest          = 1'b0;
    pixelCountNext          = pixelCount;
    // Gated by reset so a mid-chunk reset stops pushes in the same cycle.
    responseFifoWriteEnable = (state == EMIT) && !responseFifoFull && !reset;

    case (state)
      IDLE: begin
        if (!requestFifoEmpty) begin
          readEnableNext = 1'b1;
          stateNext      = READ;
        end
      end
      READ: begin
        stateNext = CAPTURE;
      end
      CAPTURE: begin
        captureRequest = 1'b1;
        pixelCountNext = '0;
        stateNext      = EMIT;
      end
      EMIT: begin
        if (responseFifoWriteEnable) begin
          pixelCountNext = pixelCount + CHUNK_BITS'(1);
          if (pixelCount == '1) begin
            stateNext = IDLE;
          end
        end
      end
      default: begin
        stateNext = IDLE;
      end
    endcase
  end

  video_pattern_pixel #(
    .X_BITS         (X_BITS),
    .Y_BITS         (Y_BITS),
    .BITS_PER_PIXEL (BITS_PER_PIXEL),
    .CHECK_BITS     (CHECK_BITS)
  ) pixelGen (
    .x               ({chunkLatched, pixelCount}),
    .y               (rowLatched),
    .mode            (modeLatched),
    .foregroundColor (foregroundLatched),
    .backgroundColor (backgroundLatched),
    .pixel           (responseFifoWriteData)
  );

endmodule

// File: doc/video_pattern_source.md
# video_pattern_source

Terminal pixel source at the upstream end of a video pipeline filter chain. It answers chunk requests that a filter element such as the integer scaler places in its upstream request FIFO. For each request it reads the request word, decodes the row and chunk column, and writes 2^CHUNK_BITS generated test-pattern pixels into the upstream response FIFO. It stands in for a framebuffer or generator during bring-up and in pipeline benches.

## Interface
- CHUNK_BITS, 5, log2 of pixels per request chunk
- X_BITS, 11, horizontal pixel coordinate width
- Y_BITS, 11, vertical pixel coordinate width
- BITS_PER_PIXEL, 16, pixel word width
- CHECK_BITS, 4, log2 of checkerboard square size
- REQUEST_BITS, Y_BITS+X_BITS-CHUNK_BITS, request word width (derived, not overridden)

Ports:
- sourceClock  in  1  sole clock; all logic on rising edge
- reset  in  1  synchronous, active-high
- patternMode  in  2  0=SOLID, 1=BARS, 2=CHECKER, 3=XOR
- foregroundColor  in  BITS_PER_PIXEL  primary color
- backgroundColor  in  BITS_PER_PIXEL  secondary color
- requestFifoReadEnable  out  1  pop request FIFO (registered)
- requestFifoEmpty  in  1  request FIFO empty
- requestFifoReadData  in  REQUEST_BITS  {row[Y_BITS-1:0], chunk[X_BITS-CHUNK_BITS-1:0]}
- responseFifoWriteEnable  out  1  push pixel
- responseFifoFull  in  1  response FIFO full
- responseFifoWriteData  out  BITS_PER_PIXEL  pixel word

## Operation
- FIFO read model: readData is valid in the cycle after the readEnable cycle (non-FWFT).
- State machine:
  - IDLE: if !requestFifoEmpty, set readEnable<=1 and go to READ.
  - READ: readEnable is high for exactly one cycle; set readEnable<=0 and go to CAPTURE.
  - CAPTURE: latch row, chunk, patternMode, foregroundColor and backgroundColor; clear pixelCount; go to EMIT.
  - EMIT: each cycle with a write, increment pixelCount. After the write at pixelCount = 2^CHUNK_BITS-1, go to IDLE.
- Pixel coordinates: x = {chunk, pixelCount} (X_BITS wide), y = row.
- Pixel function (configuration as latched in CAPTURE):
  - SOLID: foregroundColor.
  - BARS: x[X_BITS-1 -: 3] odd gives foregroundColor, else backgroundColor (8 bars).
  - CHECKER: x[CHECK_BITS] ^ y[CHECK_BITS] gives foregroundColor, else backgroundColor.
  - XOR: (x ^ y) zero-extended or truncated (low bits kept) to BITS_PER_PIXEL. The operands are zero-extended to max(X_BITS,Y_BITS).
- Configuration changes during EMIT do not affect the current chunk.
- responseFifoWriteEnable = (state==EMIT) && !responseFifoFull && !reset. This is combinational so full is honored in the same cycle.
- responseFifoWriteData = pixel function of the latched request and pixelCount (combinational). It is meaningful only while responseFifoWriteEnable is high.

## Timing
- Reset values:
  - state IDLE, requestFifoReadEnable 0, responseFifoWriteEnable 0, pixelCount 0.
  - Latched row, chunk, colors and mode are 0, so writeData equals SOLID of color 0.
- Reset asserted mid-chunk: writeEnable drops in the same cycle. The machine is IDLE after that edge and the partial chunk is abandoned; the downstream side flushes.
- Reset during READ: the pop still completes at that edge because readEnable is already registered high. The request is discarded.
- Latency: empty falls before edge T. readEnable is high in cycle T+1. The first pixel is written in cycle T+3. Without backpressure the last pixel is at T+2+2^CHUNK_BITS.
- Throughput: 2^CHUNK_BITS+3 cycles per chunk.
- Backpressure: full high stalls EMIT with no write and pixelCount held. There is no limit on stall length.
- readEnable never asserts when requestFifoEmpty was high at the deciding edge. There is never more than one pop per request.
- Coordinate wrap: x is exactly X_BITS bits and never exceeds them, since chunk and pixelCount concatenate exactly.

## Structure
- Package video_pattern_pkg:
  - PATTERN_SOLID/BARS/CHECKER/XOR constants.
  - State encodings IDLE/READ/CAPTURE/EMIT.
  - REQUEST_BITS derivation helper.
- Sub-module video_pattern_pixel: purely combinational (x, y, mode, fg, bg) → pixel, shared with future generator sources.

## Test plan
- SOLID, fg=16'hF800, one request {row=0, chunk=0} → exactly 32 writes of 16'hF800. readEnable is high for one cycle. Then IDLE.
- BARS, X_BITS=11, fg=16'hFFFF, bg=0, request chunk=8 (x=256..287) → bar 1, all 16'hFFFF. Chunk=0 → all 0.
- CHECKER, request {row=16, chunk=0} → pixels 0–15 are fg and 16–31 are bg. Row=0 gives the inverse.
- XOR, request {row=3, chunk=1} → pixel i equals (32+i)^3. Toggle full high for 5 cycles mid-chunk → no writes while full, no skipped or duplicated values, still 32 total.
- Three back-to-back queued requests → three chunks in order, each preceded by exactly one readEnable pulse. The gap between chunks is 3 cycles.
- Reset asserted at pixel 10 → writeEnable low in the same cycle. After deassert, the next request is served from pixel 0. patternMode changed mid-chunk → the current chunk is unaffected.
